hdc_main: RTL and testbench
===========================

// Module: hdc_main
// PURPOSE
//  Hyperdimensional-computing SMS classifier: encodes an ASCII message as a bundled
//  character-trigram hypervector and labels it ham/spam by Hamming distance to two
//  stored class prototypes. Top of the inference datapath; the bench drives one message at a time.
// PARAMETERS
//  MAX_CHARS  200        message buffer capacity in 8-bit characters
//  D          256        hypervector dimension (bits)
//  BASE_HV    D'h..      seed item hypervector; HV(c) = rotl(BASE_HV, c), c = char code 0..255
//  HAM_HV     D'h..      ham class prototype
//  SPAM_HV    D'h..      spam class prototype
// PORTS
//  clk     in   1              rising-edge clock
//  reset   in   1              synchronous, active-high
//  msg     in   8*MAX_CHARS    packed chars; char 0 = msg[8*MAX_CHARS-1 -: 8], MSB-first
//  length  in   8              number of valid chars, values above MAX_CHARS clamp to MAX_CHARS
//  label   in   2              ground-truth tag (00 ham, 01 spam); reserved, ignored by logic
//  result  out  2              00 ham, 01 spam, 11 inconclusive/busy (10 never driven)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. Reset: state IDLE, all counters 0,
//    result=11, captured msg/length cleared to 0.
//  - Capture: in any state, if {msg,length} differs from captured copy (compared each edge),
//    latch them, clear counters, set result=11, go to ENCODE with i=0. New input mid-run restarts.
//  - L = min(length, MAX_CHARS). If L<3: skip to DONE with result=11 one cycle after capture.
//  - ENCODE: one trigram per cycle, i = 0..L-3:
//    g = rotl(HV(c[i]),2) ^ rotl(HV(c[i+1]),1) ^ HV(c[i+2]); rotl is bitwise rotate within D.
//    Per-bit counter k (8 bits, max 198 so no overflow) increments when g[k]=1.
//  - THRESH (1 cycle): n = L-2; Q[k] = (2*cnt[k] > n) ? 1 : 0 (exact half -> 0).
//  - COMPARE (1 cycle): dh = popcount(Q^HAM_HV), ds = popcount(Q^SPAM_HV);
//    dh<ds -> 00; ds<dh -> 01; equal -> 11. Register into result; go DONE.
//  - DONE: hold result until reset or new capture. IDLE behaves as DONE with result=11.
//  - Latency for L>=3: result valid exactly L cycles after the capture edge
//    (L-2 ENCODE + THRESH + COMPARE); result=11 throughout.
//  - Characters beyond L are ignored regardless of content; label never affects result.
//  - Fully synchronous; no combinational path from inputs to result.
// TESTING
//  - Reset held 2 cycles -> result=11; after release with msg=0,length=0 -> result stays 11.
//  - length=2, msg "hi" -> result=11 one cycle after capture.
//  - Set HAM_HV = encoding of "aaaa" (= rotl(B,'a'*?) trigram), SPAM_HV=~HAM_HV; msg "aaaa",
//    length=4 -> result=11 for 3 cycles, 00 on the 4th cycle after capture.
//  - Same prototypes swapped -> result 01 after 4 cycles; HAM_HV=SPAM_HV -> result 11.
//  - Change msg at ENCODE cycle 5 of a length-200 run -> restart, result=11, final value
//    valid 200 cycles after second capture and equals value for the new msg alone.
//  - length=250 with 200 chars -> identical result/latency to length=200;
//    toggling label only -> no restart, result unchanged.

Source files
------------

// File: rtl/hdc_main_if.sv
// hdc_main_if
// Purpose: groups the message bus of the HDC SMS classifier so the design and
// its driver share one bundle of signals.
// Signals:
//   msg     packed message characters, char 0 in the top byte
//   length  number of valid characters in msg
//   label   ground-truth tag carried alongside the message, not used for inference
//   result  classification: 00 ham, 01 spam, 11 inconclusive/busy
// Modports:
//   master  drives msg/length/label, observes result
//   slave   the classifier: reads msg/length/label, drives result
interface hdc_main_if #(
    parameter int MAX_CHARS = 200
);
    logic [8*MAX_CHARS-1:0] msg;
    logic [7:0]             length;
    logic [1:0]             label;
    logic [1:0]             result;

    modport master (
        output msg,
        output length,
        output label,
        input  result
    );

    modport slave (
        input  msg,
        input  length,
        input  label,
        output result
    );
endinterface

// File: rtl/hdc_main.sv
// hdc_main
// Purpose: hyperdimensional-computing SMS classifier. A message is encoded as
// the bundle (bitwise majority) of its character-trigram hypervectors and is
// labelled ham or spam by Hamming distance to two stored class prototypes.
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high
//   bus     hdc_main_if slave: msg/length/label in, result out
// Parameters:
//   MAX_CHARS  message buffer capacity in characters
//   D          hypervector dimension in bits
//   BASE_HV    seed item vector; the item vector of char c is BASE_HV rotated left by c
//   HAM_HV     ham class prototype
//   SPAM_HV    spam class prototype
module hdc_main #(
    parameter int           MAX_CHARS = 200,
    parameter int           D         = 256,
    parameter logic [D-1:0] BASE_HV   = 256'h9E3779B9_7F4A7C15_F39CC060_5CEDC834_1082276B_F3A27251_F86C6A11_D0C18E95,
    parameter logic [D-1:0] HAM_HV    = 256'h243F6A88_85A308D3_13198A2E_03707344_A4093822_299F31D0_082EFA98_EC4E6C89,
    parameter logic [D-1:0] SPAM_HV   = 256'h452821E6_38D01377_BE5466CF_34E90C6C_C0AC29B7_C97C50DD_3F84D5B5_B5470917
) (
    input  logic      clk,
    input  logic      reset,
    hdc_main_if.slave bus
);

    localparam int DW = $clog2(D + 1);

    typedef enum logic [2:0] {
        IDLE,
        ENCODE,
        THRESH,
        COMPARE,
        DONE
    } stateT;

    stateT                  stateQ, stateD;
    logic [8*MAX_CHARS-1:0] msgQ;
    logic [7:0]             lengthQ;
    logic [7:0]             idxQ, idxD;
    logic [1:0]             resultQ, resultD;
    logic [7:0]             cntQ [D];
    logic [D-1:0]           bundleQ, bundleD;

    logic                   capture;
    logic [7:0]             effLen;
    logic [7:0]             newLen;
    logic [7:0]             nTri;
    logic [15:0]            shamt;
    logic [23:0]            window;
    logic [D-1:0]           trigramHv;
    logic [DW-1:0]          distHam, distSpam;
    logic                   unusedLabel;

    // Rotate left within D bits; the amount wraps modulo D.
    function automatic logic [D-1:0] rotl(input logic [D-1:0] v, input int amt);
        logic [2*D-1:0] dbl;
        int             a;
        a   = amt % D;
        dbl = {v, v} << a;
        return dbl[2*D-1:D];
    endfunction

    // Lengths beyond the buffer capacity behave as a full buffer.
    function automatic logic [7:0] clampLen(input logic [7:0] len);
        return (int'(len) > MAX_CHARS) ? 8'(MAX_CHARS) : len;
    endfunction

    // Datapath: change detection on the input bus, the trigram hypervector for
    // the current position, the majority threshold of the bit counters and the
    // two Hamming distances against the prototypes. The trigram window is the
    // three characters starting at idxQ, brought down to the low 24 bits by a
    // single shift so char i lands in [23:16] and char i+2 in [7:0].
    always_comb begin
        capture     = (bus.msg != msgQ) || (bus.length != lengthQ);
        effLen      = clampLen(lengthQ);
        newLen      = clampLen(bus.length);
        nTri        = effLen - 8'd2;
        shamt       = 16'(8 * (MAX_CHARS - 3)) - {5'b0, idxQ, 3'b0};
        window      = 24'(msgQ >> shamt);
        trigramHv   = rotl(rotl(BASE_HV, int'(window[23:16])), 2)
                    ^ rotl(rotl(BASE_HV, int'(window[15:8])), 1)
                    ^ rotl(BASE_HV, int'(window[7:0]));
        distHam     = '0;
        distSpam    = '0;
        for (int k = 0; k < D; k++) begin
            bundleD[k] = {cntQ[k], 1'b0} > {1'b0, nTri};
            distHam    = distHam + DW'(bundleQ[k] ^ HAM_HV[k]);
            distSpam   = distSpam + DW'(bundleQ[k] ^ SPAM_HV[k]);
        end
        unusedLabel = ^bus.label;
    end

    // Next-state logic. A change on the bus wins over everything and restarts
    // the run; messages shorter than one trigram go straight to DONE with the
    // inconclusive code. ENCODE stops advancing idx on its last trigram so the
    // window never points past the valid characters.
    always_comb begin
        stateD  = stateQ;
        idxD    = idxQ;
        resultD = resultQ;
        if (capture) begin
            idxD    = '0;
            resultD = 2'b11;
            stateD  = (newLen < 8'd3) ? DONE : ENCODE;
        end else begin
            case (stateQ)
                IDLE: begin
                    resultD = 2'b11;
                end
                ENCODE: begin
                    if (idxQ == effLen - 8'd3) begin
                        stateD = THRESH;
                    end else begin
                        idxD = idxQ + 8'd1;
                    end
                end
                THRESH: begin
                    stateD = COMPARE;
                end
                COMPARE: begin
                    stateD = DONE;
                    if (distHam < distSpam) begin
                        resultD = 2'b00;
                    end else if (distSpam < distHam) begin
                        resultD = 2'b01;
                    end else begin
                        resultD = 2'b11;
                    end
                end
                DONE: begin
                    resultD = resultQ;
                end
                default: begin
                    stateD  = IDLE;
                    resultD = 2'b11;
                end
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ  <= IDLE;
            idxQ    <= '0;
            resultQ <= 2'b11;
        end else begin
            stateQ  <= stateD;
            idxQ    <= idxD;
            resultQ <= resultD;
        end
    end

    // Captured message, per-bit trigram counters and the thresholded bundle.
    // Counters cannot overflow: at most MAX_CHARS-2 trigrams are accumulated.
    always_ff @(posedge clk) begin
        if (reset) begin
            msgQ    <= '0;
            lengthQ <= '0;
            bundleQ <= '0;
            for (int k = 0; k < D; k++) begin
                cntQ[k] <= '0;
            end
        end else if (capture) begin
            msgQ    <= bus.msg;
            lengthQ <= bus.length;
            bundleQ <= '0;
            for (int k = 0; k < D; k++) begin
                cntQ[k] <= '0;
            end
        end else begin
            if (stateQ == ENCODE) begin
                for (int k = 0; k < D; k++) begin
                    cntQ[k] <= cntQ[k] + {7'b0, trigramHv[k]};
                end
            end
            if (stateQ == THRESH) begin
                bundleQ <= bundleD;
            end
        end
    end

    assign bus.result = resultQ;

endmodule

// File: tb/tb_hdc_main.sv
// tb_hdc_main
// Purpose: self-checking bench for hdc_main. Four classifier instances share
// the same message stream but hold different prototypes: the encoding of
// "aaaa" as ham, the same swapped to spam, both prototypes equal, and an
// unrelated random pair. Directed vectors come from a table; corner cases
// (reset, mid-run restart, length clamping, label toggling) are hand-written
// sequences; random messages are checked against a bit-level reference model.
module tb_hdc_main;

    localparam int MAXC = 200;
    localparam int D    = 256;
    localparam int MW   = 8 * MAXC;

    localparam logic [D-1:0] BASE   = 256'hB7E15162_8AED2A6A_BF715880_9CF4F3C7_62E7160F_38B4DA56_A784D904_5190CFEF;
    localparam logic [D-1:0] HAM_R  = 256'hC2B2AE35_27D4EB2F_165667B1_85EBCA77_94D049BB_133111EB_BF58476D_1CE4E5B9;
    localparam logic [D-1:0] SPAM_R = 256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19;

    // Trigram of three 'a' characters; bit k of BASE rotated left by r is BASE[(k-r) mod D].
    function automatic logic [D-1:0] aaaaHv();
        logic [D-1:0] g;
        for (int k = 0; k < D; k++) begin
            g[k] = BASE[(k - 99 + 2*D) % D] ^ BASE[(k - 98 + 2*D) % D] ^ BASE[(k - 97 + 2*D) % D];
        end
        return g;
    endfunction

    localparam logic [D-1:0] HAM_A = aaaaHv();

    typedef struct {
        string      text;
        int         len;
        logic [1:0] lab;
        logic [1:0] expA;
        logic [1:0] expB;
        logic [1:0] expE;
    } vecT;

    logic clk;
    logic reset;
    int   testsRun    = 0;
    int   testsFailed = 0;

    hdc_main_if #(.MAX_CHARS(MAXC)) ifA ();
    hdc_main_if #(.MAX_CHARS(MAXC)) ifB ();
    hdc_main_if #(.MAX_CHARS(MAXC)) ifE ();
    hdc_main_if #(.MAX_CHARS(MAXC)) ifR ();

    hdc_main #(.MAX_CHARS(MAXC), .D(D), .BASE_HV(BASE), .HAM_HV(HAM_A), .SPAM_HV(~HAM_A))
        dutA (.clk(clk), .reset(reset), .bus(ifA));
    hdc_main #(.MAX_CHARS(MAXC), .D(D), .BASE_HV(BASE), .HAM_HV(~HAM_A), .SPAM_HV(HAM_A))
        dutB (.clk(clk), .reset(reset), .bus(ifB));
    hdc_main #(.MAX_CHARS(MAXC), .D(D), .BASE_HV(BASE), .HAM_HV(HAM_A), .SPAM_HV(HAM_A))
        dutE (.clk(clk), .reset(reset), .bus(ifE));
    hdc_main #(.MAX_CHARS(MAXC), .D(D), .BASE_HV(BASE), .HAM_HV(HAM_R), .SPAM_HV(SPAM_R))
        dutR (.clk(clk), .reset(reset), .bus(ifR));

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard bound on simulation time in case a wait never completes.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time %0t reached, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference classifier: count trigram bits, take the strict majority,
    // then compare Hamming distances to the two prototypes.
    function automatic logic [1:0] model(input logic [MW-1:0] m, input int len,
                                         input logic [D-1:0] ham, input logic [D-1:0] spam);
        int           L, n, dh, ds, c0, c1, c2;
        int           cnt [D];
        logic [7:0]   chars [MAXC];
        logic [D-1:0] q;
        L = (len > MAXC) ? MAXC : len;
        if (L < 3) return 2'b11;
        for (int i = 0; i < MAXC; i++) chars[i] = m[MW-1-8*i -: 8];
        for (int k = 0; k < D; k++) cnt[k] = 0;
        for (int t = 0; t <= L - 3; t++) begin
            c0 = int'(chars[t]);
            c1 = int'(chars[t+1]);
            c2 = int'(chars[t+2]);
            for (int k = 0; k < D; k++) begin
                if (BASE[(k - c0 - 2 + 2*D) % D] ^ BASE[(k - c1 - 1 + 2*D) % D] ^ BASE[(k - c2 + 2*D) % D])
                    cnt[k]++;
            end
        end
        n = L - 2;
        for (int k = 0; k < D; k++) q[k] = (2 * cnt[k] > n);
        dh = $countones(q ^ ham);
        ds = $countones(q ^ spam);
        if (dh < ds) return 2'b00;
        if (ds < dh) return 2'b01;
        return 2'b11;
    endfunction

    function automatic logic [MW-1:0] packMsg(input string s);
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < s.len(); i++) m[MW-1-8*i -: 8] = s[i];
        return m;
    endfunction

    function automatic logic [MW-1:0] randMsg();
        logic [MW-1:0] m;
        for (int i = 0; i < MAXC; i++) m[MW-1-8*i -: 8] = 8'($urandom_range(0, 255));
        return m;
    endfunction

    // Drive all four instances identically on a falling edge.
    task automatic applyStimulus(input logic [MW-1:0] m, input int len, input logic [1:0] lab);
        @(negedge clk);
        ifA.msg = m; ifA.length = 8'(len); ifA.label = lab;
        ifB.msg = m; ifB.length = 8'(len); ifB.label = lab;
        ifE.msg = m; ifE.length = 8'(len); ifE.label = lab;
        ifR.msg = m; ifR.length = 8'(len); ifR.label = lab;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: result=%b, expected %b", name, act, exp);
        end
    endtask

    // Apply one message and check the busy code one cycle before the answer
    // and the answer itself exactly L cycles after the capture edge.
    task automatic runVector(input string name, input logic [MW-1:0] m, input int len, input logic [1:0] lab,
                             input logic [1:0] eA, input logic [1:0] eB, input logic [1:0] eE, input logic [1:0] eR);
        int L, lat;
        L   = (len > MAXC) ? MAXC : len;
        lat = (L < 3) ? 1 : L;
        applyStimulus(m, len, lab);
        @(posedge clk);
        if (lat > 1) begin
            repeat (lat - 1) @(posedge clk);
            #1;
            checkOutput({name, "/busyA"}, ifA.result, 2'b11);
            checkOutput({name, "/busyR"}, ifR.result, 2'b11);
        end
        @(posedge clk);
        #1;
        checkOutput({name, "/A"}, ifA.result, eA);
        checkOutput({name, "/B"}, ifB.result, eB);
        checkOutput({name, "/E"}, ifE.result, eE);
        checkOutput({name, "/R"}, ifR.result, eR);
    endtask

    initial begin
        vecT           vecs [7];
        logic [MW-1:0] m1, m2;
        logic [1:0]    expA2, expR2;
        int            len;

        vecs[0] = '{"aaaa",       4, 2'b00, 2'b00, 2'b01, 2'b11};
        vecs[1] = '{"hi",         2, 2'b00, 2'b11, 2'b11, 2'b11};
        vecs[2] = '{"aaa",        3, 2'b01, 2'b00, 2'b01, 2'b11};
        vecs[3] = '{"aaaaaaaa",   8, 2'b00, 2'b00, 2'b01, 2'b11};
        vecs[4] = '{"aaaa",       0, 2'b00, 2'b11, 2'b11, 2'b11};
        vecs[5] = '{"xy",         1, 2'b01, 2'b11, 2'b11, 2'b11};
        vecs[6] = '{"aaaa",       4, 2'b01, 2'b00, 2'b01, 2'b11};

        // Reset held for two cycles with an all-zero bus.
        reset = 1'b1;
        applyStimulus('0, 0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset/A", ifA.result, 2'b11);
        checkOutput("reset/B", ifB.result, 2'b11);
        checkOutput("reset/R", ifR.result, 2'b11);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("idleAfterReset/A", ifA.result, 2'b11);
        checkOutput("idleAfterReset/R", ifR.result, 2'b11);

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            m1 = packMsg(vecs[v].text);
            runVector($sformatf("vec%0d", v), m1, vecs[v].len, vecs[v].lab,
                      vecs[v].expA, vecs[v].expB, vecs[v].expE,
                      model(m1, vecs[v].len, HAM_R, SPAM_R));
        end

        // Restart in the middle of a full-length run.
        m1 = randMsg();
        m2 = randMsg();
        applyStimulus(m1, 200, 2'b00);
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("midRun/busy", ifA.result, 2'b11);
        expA2 = model(m2, 200, HAM_A, ~HAM_A);
        expR2 = model(m2, 200, HAM_R, SPAM_R);
        runVector("restart", m2, 200, 2'b00, expA2, model(m2, 200, ~HAM_A, HAM_A), 2'b11, expR2);

        // Oversized length behaves as a full buffer.
        runVector("len250", m2, 250, 2'b00, model(m2, 250, HAM_A, ~HAM_A),
                  model(m2, 250, ~HAM_A, HAM_A), 2'b11, model(m2, 250, HAM_R, SPAM_R));

        // Label change alone must not restart the run.
        applyStimulus(m2, 250, 2'b10);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("labelToggle/A", ifA.result, expA2);
            checkOutput("labelToggle/R", ifR.result, expR2);
        end

        // Randomized messages against the reference model.
        for (int t = 0; t < 12; t++) begin
            m1  = randMsg();
            len = (t % 3 == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(3, 255));
            runVector($sformatf("rand%0d", t), m1, len, 2'($urandom_range(0, 3)),
                      model(m1, len, HAM_A, ~HAM_A), model(m1, len, ~HAM_A, HAM_A),
                      model(m1, len, HAM_A, HAM_A), model(m1, len, HAM_R, SPAM_R));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
